pixel_write_arbiter: RTL and testbench

//  Shares the single VGA pixel-write port between N drawing engines (background, gold, stone, hook, number display).

---
 rtl/view_arb_pkg.sv | 16 +
 rtl/rr_priority_picker.sv | 33 +++
 rtl/pixel_write_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_pixel_write_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/view_arb_pkg.sv
// Shared widths, arbiter state encoding and default grant timeout for the view-side pixel-port arbiters.
package view_arb_pkg;

   localparam int X_W         = 9;
   localparam int Y_W         = 8;
   localparam int C_W         = 12;
   localparam int HOLD_W      = 17;
   localparam int TIMEOUT_DEF = 131071;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BURST   = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational one-hot winner picker: round-robin search starting at i_ptr (wrapping),
// or lowest-index-wins when i_fixed is set.
module rr_priority_picker #(
   parameter int N     = 5,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   input  logic             i_fixed,
   output logic [N-1:0]     o_onehot,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid
);

   int w_j;

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_valid  = 1'b0;
      w_j      = 0;
      for (int k = 0; k < N; k++) begin
         w_j = i_fixed ? k : int'(i_ptr) + k;
         if (w_j >= N) w_j = w_j - N;
         if (!o_valid && i_req[w_j]) begin
            o_valid       = 1'b1;
            o_onehot[w_j] = 1'b1;
            o_idx         = IDX_W'(w_j);
         end
      end
   end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Shares the VGA pixel-write port between N_REQ drawing engines, one whole burst per grant.
// Optional colour keying of sprite engines is enabled with `define PIXEL_ARB_KEY_EN.
//
// state      | meaning
// ST_IDLE    | no owner, waiting for any req
// ST_BURST   | one engine owns the port, its pixels forwarded with 1-cycle latency
// ST_RELEASE | single dead cycle after a burst, writeEn held low
module pixel_write_arbiter
   import view_arb_pkg::*;
#(
   parameter int             N_REQ      = 5,
   parameter bit             FIXED_PRIO = 1'b0,
   parameter int             TIMEOUT    = TIMEOUT_DEF,
   parameter logic [C_W-1:0] KEY_COLOR  = 12'h000
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ-1:0]     done,
   input  logic [X_W*N_REQ-1:0] pix_x,
   input  logic [Y_W*N_REQ-1:0] pix_y,
   input  logic [C_W*N_REQ-1:0] pix_color,
   input  logic [N_REQ-1:0]     pix_we,
   input  logic [N_REQ-1:0]     key_mask,
   output logic [N_REQ-1:0]     grant,
   output logic [X_W-1:0]       X_out,
   output logic [Y_W-1:0]       Y_out,
   output logic [C_W-1:0]       Color_out,
   output logic                 writeEn,
   output logic                 busy,
   output logic                 timeout
);

   localparam int                IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [HOLD_W-1:0] HOLD_TC  = HOLD_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);

   arb_state_e        r_state;
   arb_state_e        w_state_nxt;
   logic [N_REQ-1:0]  r_grant;
   logic [IDX_W-1:0]  r_owner;
   logic [IDX_W-1:0]  r_ptr;
   logic [HOLD_W-1:0] r_hold;
   logic [X_W-1:0]    r_x;
   logic [Y_W-1:0]    r_y;
   logic [C_W-1:0]    r_color;
   logic              r_we;
   logic              r_timeout;

   logic [N_REQ-1:0]  w_win_onehot;
   logic [IDX_W-1:0]  w_win_idx;
   logic              w_win_valid;
   logic [X_W-1:0]    w_sel_x;
   logic [Y_W-1:0]    w_sel_y;
   logic [C_W-1:0]    w_sel_color;
   logic              w_sel_we;
   logic              w_sel_done;
   logic              w_sel_req;
   logic              w_we_eff;
   logic              w_hold_tc;
   logic              w_exit;
   logic              w_forced;

   rr_priority_picker #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .i_fixed  (FIXED_PRIO),
      .o_onehot (w_win_onehot),
      .o_idx    (w_win_idx),
      .o_valid  (w_win_valid)
   );

   // Grant is one-hot, so a plain per-index select acts as the owner mux.
   always_comb begin
      w_sel_x     = '0;
      w_sel_y     = '0;
      w_sel_color = '0;
      w_sel_we    = 1'b0;
      w_sel_done  = 1'b0;
      w_sel_req   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_grant[i]) begin
            w_sel_x     = pix_x[X_W*i +: X_W];
            w_sel_y     = pix_y[Y_W*i +: Y_W];
            w_sel_color = pix_color[C_W*i +: C_W];
            w_sel_we    = pix_we[i];
            w_sel_done  = done[i];
            w_sel_req   = req[i];
         end
      end
   end

`ifdef PIXEL_ARB_KEY_EN
   logic w_sel_key;

   always_comb begin
      w_sel_key = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_grant[i]) w_sel_key = key_mask[i];
      end
   end

   // Key on the colour presented this cycle, not the registered Color_out.
   assign w_we_eff = w_sel_we && !(w_sel_key && (w_sel_color == KEY_COLOR));
`else
   logic w_unused_key;

   assign w_we_eff     = w_sel_we;
   assign w_unused_key = ^{key_mask, KEY_COLOR};
`endif

   assign w_hold_tc = (r_hold == HOLD_TC);
   assign w_exit    = (r_state == ST_BURST) && (w_sel_done || !w_sel_req || w_hold_tc);
   assign w_forced  = w_hold_tc && !w_sel_done && w_sel_req;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:    if (w_win_valid) w_state_nxt = ST_BURST;
         ST_BURST:   if (w_exit)      w_state_nxt = ST_RELEASE;
         ST_RELEASE: w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_grant   <= '0;
         r_owner   <= '0;
         r_ptr     <= '0;
         r_hold    <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_color   <= '0;
         r_we      <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_we      <= 1'b0;
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_win_valid) begin
                  r_grant <= w_win_onehot;
                  r_owner <= w_win_idx;
                  r_hold  <= '0;
               end
            end
            ST_BURST: begin
               // The pixel of the exit cycle is still forwarded.
               r_x     <= w_sel_x;
               r_y     <= w_sel_y;
               r_color <= w_sel_color;
               r_we    <= w_we_eff;
               if (r_hold != '1) r_hold <= r_hold + HOLD_W'(1);
               if (w_exit) begin
                  r_grant   <= '0;
                  r_ptr     <= (r_owner == LAST_IDX) ? '0 : r_owner + IDX_W'(1);
                  r_timeout <= w_forced;
               end
            end
            default: ;
         endcase
      end
   end

   assign grant     = r_grant;
   assign X_out     = r_x;
   assign Y_out     = r_y;
   assign Color_out = r_color;
   assign writeEn   = r_we;
   assign busy      = (r_state != ST_IDLE);
   assign timeout   = r_timeout;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: round-robin and fixed-priority instances share stimulus;
// pixel forwarding is checked through an expected-pixel queue.
module tb_pixel_write_arbiter;

   localparam int N = 5;

   logic           clk = 1'b0;
   logic           resetn;
   logic [N-1:0]   req, done, pix_we, key_mask;
   logic [9*N-1:0] pix_x;
   logic [8*N-1:0] pix_y;
   logic [12*N-1:0] pix_color;

   logic [N-1:0] grant_rr, grant_fx;
   logic [8:0]   x_rr, x_fx;
   logic [7:0]   y_rr, y_fx;
   logic [11:0]  c_rr, c_fx;
   logic         we_rr, we_fx, busy_rr, busy_fx, to_rr, to_fx;

   pixel_write_arbiter #(.N_REQ(N), .FIXED_PRIO(1'b0), .TIMEOUT(16)) u_dut (
      .clk(clk), .resetn(resetn), .req(req), .done(done), .pix_x(pix_x), .pix_y(pix_y),
      .pix_color(pix_color), .pix_we(pix_we), .key_mask(key_mask), .grant(grant_rr),
      .X_out(x_rr), .Y_out(y_rr), .Color_out(c_rr), .writeEn(we_rr), .busy(busy_rr),
      .timeout(to_rr));

   pixel_write_arbiter #(.N_REQ(N), .FIXED_PRIO(1'b1), .TIMEOUT(16)) u_fix (
      .clk(clk), .resetn(resetn), .req(req), .done(done), .pix_x(pix_x), .pix_y(pix_y),
      .pix_color(pix_color), .pix_we(pix_we), .key_mask(key_mask), .grant(grant_fx),
      .X_out(x_fx), .Y_out(y_fx), .Color_out(c_fx), .writeEn(we_fx), .busy(busy_fx),
      .timeout(to_fx));

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] req;
      int           len;
      bit           drop;
      logic [N-1:0] exp_rr;
      logic [N-1:0] exp_fx;
   } row_t;

   typedef struct {
      logic [8:0]  x;
      logic [7:0]  y;
      logic [11:0] c;
      logic        we;
   } pix_t;

   row_t rows[12];
   pix_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int oh2idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic drive_pix(input int w, input logic we, input logic [11:0] col, input logic we_exp);
      pix_t e;
      for (int i = 0; i < N; i++) begin
         pix_x[9*i +: 9]      = 9'($urandom);
         pix_y[8*i +: 8]      = 8'($urandom);
         pix_color[12*i +: 12] = 12'($urandom);
         pix_we[i]            = 1'($urandom);
      end
      pix_color[12*w +: 12] = col;
      pix_we[w]             = we;
      e.x  = pix_x[9*w +: 9];
      e.y  = pix_y[8*w +: 8];
      e.c  = col;
      e.we = we_exp;
      sb.push_back(e);
   endtask

   task automatic pop_check(input string name);
      pix_t e;
      n_checks++;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL %s: scoreboard empty, got writeEn %0b", name, we_rr);
      end else begin
         e = sb.pop_front();
         if ({x_rr, y_rr, c_rr, we_rr} !== {e.x, e.y, e.c, e.we}) begin
            n_err++;
            $display("FAIL %s: got x=%0d y=%0d c=%0h we=%0b expected x=%0d y=%0d c=%0h we=%0b",
                     name, x_rr, y_rr, c_rr, we_rr, e.x, e.y, e.c, e.we);
         end
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      req = '0; done = '0; pix_we = '0; key_mask = '0;
      pix_x = '0; pix_y = '0; pix_color = '0;
      step();
      step();
      chk("rst_grant", 32'(grant_rr), 32'(0));
      chk("rst_out", 32'({x_rr, y_rr, c_rr}), 32'(0));
      chk("rst_flags", 32'({we_rr, busy_rr, to_rr}), 32'(0));
      resetn = 1'b1;
      sb.delete();
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while ((busy_rr || busy_fx) && k < 8) begin
         step();
         k++;
      end
      chk(name, 32'({busy_rr, busy_fx}), 32'(0));
   endtask

   initial begin
      int   w, held, pulses;
      logic last, we;
      logic k0;

      rows[0]  = '{5'b00100, 3,  1'b0, 5'b00100, 5'b00100};
      rows[1]  = '{5'b00011, 5,  1'b0, 5'b00001, 5'b00001};
      rows[2]  = '{5'b00011, 4,  1'b1, 5'b00010, 5'b00001};
      rows[3]  = '{5'b00011, 2,  1'b0, 5'b00001, 5'b00001};
      rows[4]  = '{5'b10001, 6,  1'b0, 5'b10000, 5'b00001};
      rows[5]  = '{5'b10001, 1,  1'b0, 5'b00001, 5'b00001};
      rows[6]  = '{5'b10001, 3,  1'b0, 5'b10000, 5'b00001};
      rows[7]  = '{5'b11111, 4,  1'b1, 5'b00001, 5'b00001};
      rows[8]  = '{5'b11111, 10, 1'b0, 5'b00010, 5'b00001};
      rows[9]  = '{5'b01000, 2,  1'b0, 5'b01000, 5'b01000};
      rows[10] = '{5'b11111, 3,  1'b0, 5'b10000, 5'b00001};
      rows[11] = '{5'b10110, 2,  1'b0, 5'b00010, 5'b00010};

      do_reset();

      for (int r = 0; r < 12; r++) begin
         req = rows[r].req;
         step();
         chk("grant_rr", 32'(grant_rr), 32'(rows[r].exp_rr));
         chk("grant_fix", 32'(grant_fx), 32'(rows[r].exp_fx));
         chk("busy_burst", 32'(busy_rr), 32'(1));
         w = oh2idx(rows[r].exp_rr);
         for (int p = 0; p < rows[r].len; p++) begin
            last = (p == rows[r].len - 1);
            we   = 1'($urandom);
            drive_pix(w, we, 12'($urandom), we);
            if (last) begin
               if (rows[r].drop) req = '0;
               else              done = rows[r].exp_rr;
            end
            step();
            done = '0;
            pop_check("pix");
            if (!last) chk("grant_hold", 32'(grant_rr), 32'(rows[r].exp_rr));
         end
         chk("rel_grant", 32'(grant_rr), 32'(0));
         chk("rel_busy", 32'(busy_rr), 32'(1));
         req = '0;
         pix_we = '0;
         step();
         chk("idle_we", 32'({we_rr, busy_rr}), 32'(0));
         wait_idle("row_idle");
      end

      // back-to-back bursts with req held, foreign done ignored, done+req-drop together
      do_reset();
      req = 5'b00011;
      step();
      chk("b2b_g0", 32'(grant_rr), 32'(5'b00001));
      for (int p = 0; p < 10; p++) begin
         drive_pix(0, 1'b1, 12'($urandom), 1'b1);
         done = (p == 9) ? 5'b00001 : (p == 3) ? 5'b00010 : 5'b00000;
         step();
         done = '0;
         pop_check("b2b_pix0");
         if (p < 9) chk("b2b_hold0", 32'(grant_rr), 32'(5'b00001));
      end
      chk("b2b_rel", 32'({grant_rr, busy_rr}), 32'({5'b00000, 1'b1}));
      step();
      chk("b2b_gap", 32'({grant_rr, busy_rr, we_rr}), 32'(0));
      step();
      chk("b2b_g1", 32'(grant_rr), 32'(5'b00010));
      for (int p = 0; p < 4; p++) begin
         drive_pix(1, 1'b1, 12'($urandom), 1'b1);
         if (p == 3) begin
            done = 5'b00010;
            req  = 5'b00001;
         end
         step();
         done = '0;
         pop_check("b2b_pix1");
      end
      chk("b2b_rel1", 32'(grant_rr), 32'(0));
      step();
      chk("b2b_gap1", 32'({grant_rr, busy_rr}), 32'(0));
      step();
      chk("b2b_g0b", 32'(grant_rr), 32'(5'b00001));
      drive_pix(0, 1'b1, 12'($urandom), 1'b1);
      done = 5'b00001;
      step();
      done = '0;
      pop_check("b2b_pix2");
      req = '0;
      pix_we = '0;
      step();

      // forced release after 16 held cycles; ptr is 1 so engine 1 wins
      req = 5'b00010;
      step();
      held   = (grant_rr == 5'b00010) ? 1 : 0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (to_rr) pulses++;
         if (grant_rr == 5'b00010) held++;
         else break;
      end
      chk("to_held", 32'(held), 32'(16));
      chk("to_pulse_at_drop", 32'(to_rr), 32'(1));
      req = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (to_rr) pulses++;
      end
      chk("to_pulses", 32'(pulses), 32'(1));
      req = 5'b00111;
      step();
      chk("to_ptr2", 32'(grant_rr), 32'(5'b00100));
      req = '0;
      step();
      wait_idle("to_idle");

      // colour keying on engine 1
      do_reset();
`ifdef PIXEL_ARB_KEY_EN
      k0 = 1'b0;
`else
      k0 = 1'b1;
`endif
      req = 5'b00010;
      step();
      chk("key_grant", 32'(grant_rr), 32'(5'b00010));
      key_mask = 5'b00010;
      drive_pix(1, 1'b1, 12'h000, k0);
      step();
      pop_check("key_black");
      drive_pix(1, 1'b1, 12'hFC0, 1'b1);
      step();
      pop_check("key_gold");
      key_mask = 5'b00000;
      drive_pix(1, 1'b1, 12'h000, 1'b1);
      step();
      pop_check("nokey_black");
      drive_pix(1, 1'b1, 12'hFC0, 1'b1);
      done = 5'b00010;
      step();
      done = '0;
      pop_check("nokey_gold");
      req = '0;
      step();
      wait_idle("key_idle");

      // reset mid-burst
      do_reset();
      req = 5'b00100;
      step();
      chk("mid_grant", 32'(grant_rr), 32'(5'b00100));
      step();
      drive_pix(2, 1'b1, 12'h123, 1'b1);
      pix_x[9*2 +: 9] = 9'd100;
      sb.pop_back();
      step();
      chk("mid_x100", 32'({x_rr, we_rr}), 32'({9'd100, 1'b1}));
      drive_pix(2, 1'b1, 12'h456, 1'b1);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_flags", 32'({grant_rr, we_rr, busy_rr}), 32'(0));
      chk("arst_x", 32'(x_rr), 32'(0));
      sb.delete();
      req = '0;
      step();
      resetn = 1'b1;
      step();
      chk("post_rst", 32'({grant_rr, we_rr, busy_rr}), 32'(0));
      req = 5'b00110;
      step();
      chk("post_rst_ptr0", 32'(grant_rr), 32'(5'b00010));
      req = '0;
      step();
      wait_idle("end_idle");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
